// File: rtl/mbist_pkg.sv
// Shared types and constants for the MBIST sequencer.
// MBIST_COMPLEMENT_EN adds the descending complement write/read passes.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
`ifdef MBIST_COMPLEMENT_EN
    WRITE_C,
    READ_C,
`endif
    CHECK,
    DONE
  } state_t;

  localparam int         NUM_BG = 6;
  localparam logic [2:0] Q_LAST = 3'(NUM_BG - 1);

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the MBIST sequencer; `last` marks the final
// address of a pass in the current direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr <= '0;
    else if (load)
      addr <= load_val;
    else if (en)
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_controller.sv
// MBIST sequencer: six background patterns, write pass then read/compare pass
// each, sticky fail with first-failure capture. Option: MBIST_COMPLEMENT_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WRITE   | ascending write of data_t
// READ    | ascending read, expected value registered for compare
// WRITE_C | descending write of ~data_t (MBIST_COMPLEMENT_EN)
// READ_C  | descending read against ~data_t (MBIST_COMPLEMENT_EN)
// CHECK   | drain cycle for the last compare, then next background or DONE
// DONE    | results held until the next start
module mbist_controller
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [2:0]        q,
  input  logic [DATA_W-1:0] data_t,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_q
);

  state_t state;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_en;
  logic              ag_down;
  logic              ag_last;
  logic              start_ok;

  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_q;

  assign start_ok = start && (state == IDLE || state == DONE);

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_val (ag_load_val),
    .en       (ag_en),
    .down     (ag_down),
    .addr     (mem_addr),
    .last     (ag_last)
  );

  // Ascending passes rely on natural wrap from N-1 back to 0.
  always_comb begin
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_en       = 1'b0;
    ag_down     = 1'b0;
    case (state)
      IDLE, DONE: ag_load = start;
      WRITE:      ag_en   = 1'b1;
`ifdef MBIST_COMPLEMENT_EN
      READ: begin
        ag_en       = 1'b1;
        ag_load     = ag_last;
        ag_load_val = '1;
      end
      WRITE_C: begin
        ag_en       = 1'b1;
        ag_down     = 1'b1;
        ag_load     = ag_last;
        ag_load_val = '1;
      end
      READ_C: begin
        ag_en   = 1'b1;
        ag_down = 1'b1;
        ag_load = ag_last;
      end
`else
      READ:       ag_en   = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= WRITE;
            q      <= 3'd0;
            busy   <= 1'b1;
            done   <= 1'b0;
            mem_we <= 1'b1;
          end
        end
        WRITE: begin
          if (ag_last) begin
            state  <= READ;
            mem_we <= 1'b0;
            mem_re <= 1'b1;
          end
        end
        READ: begin
          if (ag_last) begin
`ifdef MBIST_COMPLEMENT_EN
            state  <= WRITE_C;
            mem_re <= 1'b0;
            mem_we <= 1'b1;
`else
            state  <= CHECK;
            mem_re <= 1'b0;
`endif
          end
        end
`ifdef MBIST_COMPLEMENT_EN
        WRITE_C: begin
          if (ag_last) begin
            state  <= READ_C;
            mem_we <= 1'b0;
            mem_re <= 1'b1;
          end
        end
        READ_C: begin
          if (ag_last) begin
            state  <= CHECK;
            mem_re <= 1'b0;
          end
        end
`endif
        CHECK: begin
          if (q == Q_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= WRITE;
            q      <= q + 3'd1;
            mem_we <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MBIST_COMPLEMENT_EN
  assign mem_wdata = !mem_we ? '0 : (state == WRITE_C) ? ~data_t : data_t;
`else
  assign mem_wdata = mem_we ? data_t : '0;
`endif

  // Read data returns one cycle after the strobe, so expectations are staged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_q     <= 3'd0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_q    <= 3'd0;
    end else begin
      cmp_valid <= mem_re;
`ifdef MBIST_COMPLEMENT_EN
      cmp_exp   <= (state == READ_C) ? ~data_t : data_t;
`else
      cmp_exp   <= data_t;
`endif
      cmp_addr  <= mem_addr;
      cmp_q     <= q;
      if (start_ok) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_q    <= 3'd0;
      end else if (cmp_valid && (mem_rdata != cmp_exp)) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= cmp_addr;
          fail_q    <= cmp_q;
        end
      end
    end
  end

endmodule
